cell_mem_responder: RTL and testbench
=====================================

CELL_MEM_RESPONDER -- requirements
Module: cell_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default MEM_WIDTH (256), giving the number of cells.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, initiator has a request.
REQ-005 SHALL have port req_ready, output, 1, responder accepts the request this cycle.
REQ-006 SHALL have port req_op, input, op_t (2), request kind: OP_READ=0, OP_STORE=1, OP_ALLOC=2, OP_FREE=3.
REQ-007 SHALL have port req_addr, input, addr_t (16), target cell for READ/STORE/FREE; ignored for ALLOC.
REQ-008 SHALL have port req_data, input, bus_t (38), cell word for STORE/ALLOC.
REQ-009 SHALL have port rsp_valid, output, 1, response present.
REQ-010 SHALL have port rsp_ready, input, 1, initiator takes the response this cycle.
REQ-011 SHALL have port rsp_status, output, status_t, status_ok or status_err.
REQ-012 SHALL have port rsp_err, output, err_t, err_none, err_mem_full or err_mem_used.
REQ-013 SHALL have port rsp_addr, output, addr_t, cell addressed, or cell allocated.
REQ-014 SHALL have port rsp_data, output, bus_t, READ result; 0 otherwise.

Function
REQ-015 SHALL implement states IDLE, SCAN, RESP; req_ready=1 only in IDLE; request accepted when req_valid and req_ready are both 1.
REQ-016 SHALL keep one used bit per cell, a used-cell count (0..DEPTH) and a next-fit pointer (0..DEPTH-1).
REQ-017 SHALL, for READ/STORE/FREE, go IDLE->RESP on accept; rsp_valid asserts the next cycle (latency 1).
REQ-018 SHALL answer READ/STORE/FREE with req_addr >= DEPTH as status_err/err_mem_full, with no state change.
REQ-019 SHALL answer READ of a used cell with status_ok and the stored word; an unused cell with status_err/err_none and rsp_data=0.
REQ-020 SHALL, on STORE to an unused cell, write the word, set the used bit, increment the count, and return status_ok; a used cell returns status_err/err_mem_used with no write.
REQ-021 SHALL, on FREE of a used cell, clear the used bit, decrement the count, and return status_ok; an unused cell returns status_err/err_none.
REQ-022 SHALL, on ALLOC with count==DEPTH, go directly to RESP with status_err/err_mem_full and rsp_addr=0.
REQ-023 SHALL otherwise run ALLOC in SCAN, testing one cell per cycle from the pointer, which wraps DEPTH-1->0.
REQ-024 SHALL, when SCAN finds free cell a, write the word, set used[a], increment the count, set pointer=(a+1) mod DEPTH, and go to RESP with status_ok and rsp_addr=a; the free cell at the pointer gives rsp_valid 2 cycles after accept.
REQ-025 SHALL hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0; RESP->IDLE when rsp_ready=1.
REQ-026 SHALL NOT accept a new request in the cycle that RESP completes; acceptance resumes the cycle after the return to IDLE.

Reset
REQ-027 SHALL, on rst, asynchronously clear all used bits, the count and the pointer, set state to IDLE, and drive rsp_valid=0, rsp_status=status_ok, rsp_err=err_none, rsp_addr=0 and rsp_data=0.
REQ-028 SHALL NOT reset cell data storage.
REQ-029 SHALL, if rst occurs during SCAN or RESP, abandon the operation and produce no response.

Structure
REQ-030 SHALL add op_t to package general and reuse bus_t, addr_t, status_t, err_t and MEM_WIDTH from it.
REQ-031 SHALL place the used-bit array, count and next-fit search in one sub-module, cell_alloc_bitmap.

Verification
REQ-032 Reset, then ALLOC data 38'h1 -> status_ok, rsp_addr=0, rsp_valid 2 cycles after accept; next ALLOC -> rsp_addr=1.
REQ-033 STORE addr 5 data 38'hABC, then READ 5 -> 38'hABC; STORE 5 again -> status_err/err_mem_used.
REQ-034 Fill all 256 cells, then ALLOC -> status_err/err_mem_full in 1 cycle; FREE 7, then ALLOC -> rsp_addr=7 via wrap.
REQ-035 READ addr 16'h0100 -> status_err/err_mem_full; READ an unused cell 9 -> status_err/err_none, data 0.
REQ-036 Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0; assert rst mid-SCAN -> rsp_valid=0 and count=0.

Source files
------------

// File: rtl/general_pkg.sv
// Shared cell-memory types: bus/address words, response status/error codes
// and the request opcode.
package general;

  localparam int unsigned MEM_WIDTH = 256;

  typedef logic [37:0] bus_t;
  typedef logic [15:0] addr_t;

  typedef enum logic {
    status_ok  = 1'b0,
    status_err = 1'b1
  } status_t;

  typedef enum logic [1:0] {
    err_none     = 2'd0,
    err_mem_full = 2'd1,
    err_mem_used = 2'd2
  } err_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_STORE = 2'd1,
    OP_ALLOC = 2'd2,
    OP_FREE  = 2'd3
  } op_t;

endpackage

// File: rtl/cell_alloc_bitmap.sv
// Per-cell used bits, used-cell count and the next-fit pointer that the
// allocator walks one cell per cycle.
module cell_alloc_bitmap
  import general::*;
#(
  parameter  int unsigned DEPTH = MEM_WIDTH,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lookup_idx,
  output logic          lookup_used,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          ptr_adv,
  output logic [AW-1:0] ptr,
  output logic          ptr_free,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] used;
  logic [AW-1:0]    ptr_nx;

  assign lookup_used = used[lookup_idx];
  assign ptr_free    = ~used[ptr];
  assign ptr_nx      = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used  <= '0;
      count <= '0;
      ptr   <= '0;
    end else begin
      if (set_en) used[set_idx] <= 1'b1;
      if (clr_en) used[clr_idx] <= 1'b0;
      if (set_en && !clr_en)      count <= count + 1'b1;
      else if (clr_en && !set_en) count <= count - 1'b1;
      if (ptr_adv) ptr <= ptr_nx;
    end
  end

endmodule

// File: rtl/cell_mem_responder.sv
// Request/response front end for a cell memory: READ/STORE/FREE answer in one
// cycle, ALLOC performs a next-fit scan over the used bitmap.
module cell_mem_responder
  import general::*;
#(
  parameter int unsigned DEPTH = MEM_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    req_valid,
  output logic    req_ready,
  input  op_t     req_op,
  input  addr_t   req_addr,
  input  bus_t    req_data,
  output logic    rsp_valid,
  input  logic    rsp_ready,
  output status_t rsp_status,
  output err_t    rsp_err,
  output addr_t   rsp_addr,
  output bus_t    rsp_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  bus_t mem [DEPTH];
  bus_t scan_data;

  logic [AW-1:0] req_idx;
  logic          addr_ok;
  logic          lookup_used;
  logic          set_en;
  logic [AW-1:0] set_idx;
  logic          clr_en;
  logic          ptr_adv;
  logic [AW-1:0] ptr;
  logic          ptr_free;
  logic [CW-1:0] used_count;
  logic          full;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  bus_t          mem_wdata;
  logic          ld_scan;
  logic          ld_rsp;
  status_t       n_status;
  err_t          n_err;
  addr_t         n_addr;
  bus_t          n_data;

  assign req_idx   = req_addr[AW-1:0];
  assign addr_ok   = 32'(req_addr) < DEPTH;
  assign full      = (used_count == CW'(DEPTH));
  assign rsp_valid = (state == RESP);

  cell_alloc_bitmap #(.DEPTH(DEPTH)) u_bitmap (
    .clk         (clk),
    .rst         (rst),
    .lookup_idx  (req_idx),
    .lookup_used (lookup_used),
    .set_en      (set_en),
    .set_idx     (set_idx),
    .clr_en      (clr_en),
    .clr_idx     (req_idx),
    .ptr_adv     (ptr_adv),
    .ptr         (ptr),
    .ptr_free    (ptr_free),
    .count       (used_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // READ/STORE/FREE take effect at the accept edge; ALLOC takes effect at the
  // SCAN edge that finds a free cell, so the bitmap is never touched twice.
  always_comb begin
    state_nx  = state;
    req_ready = (state == IDLE);
    set_en    = 1'b0;
    set_idx   = req_idx;
    clr_en    = 1'b0;
    ptr_adv   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = req_idx;
    mem_wdata = req_data;
    ld_scan   = 1'b0;
    ld_rsp    = 1'b0;
    n_status  = status_ok;
    n_err     = err_none;
    n_addr    = req_addr;
    n_data    = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op == OP_ALLOC) begin
            n_addr = '0;
            if (full) begin
              ld_rsp   = 1'b1;
              n_status = status_err;
              n_err    = err_mem_full;
              state_nx = RESP;
            end else begin
              ld_scan  = 1'b1;
              state_nx = SCAN;
            end
          end else begin
            ld_rsp   = 1'b1;
            state_nx = RESP;
            if (!addr_ok) begin
              n_status = status_err;
              n_err    = err_mem_full;
            end else begin
              case (req_op)
                OP_READ: begin
                  if (lookup_used) n_data = mem[req_idx];
                  else             n_status = status_err;
                end
                OP_STORE: begin
                  if (lookup_used) begin
                    n_status = status_err;
                    n_err    = err_mem_used;
                  end else begin
                    set_en = 1'b1;
                    mem_we = 1'b1;
                  end
                end
                OP_FREE: begin
                  if (lookup_used) clr_en   = 1'b1;
                  else             n_status = status_err;
                end
                default: ;
              endcase
            end
          end
        end
      end
      SCAN: begin
        ptr_adv = 1'b1;
        if (ptr_free) begin
          set_en    = 1'b1;
          set_idx   = ptr;
          mem_we    = 1'b1;
          mem_waddr = ptr;
          mem_wdata = scan_data;
          ld_rsp    = 1'b1;
          n_addr    = addr_t'(ptr);
          state_nx  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_status <= status_ok;
      rsp_err    <= err_none;
      rsp_addr   <= '0;
      rsp_data   <= '0;
    end else if (ld_rsp) begin
      rsp_status <= n_status;
      rsp_err    <= n_err;
      rsp_addr   <= n_addr;
      rsp_data   <= n_data;
    end
  end

  // Cell storage and the pending ALLOC word are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[mem_waddr] <= mem_wdata;
    if (ld_scan) scan_data <= req_data;
  end

endmodule

// File: tb/tb_cell_mem_responder.sv
// Directed bench for cell_mem_responder: hand-computed responses, latencies,
// back-pressure hold and reset during an allocation scan.
module tb_cell_mem_responder;
  import general::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    req_valid;
  logic    req_ready;
  op_t     req_op;
  addr_t   req_addr;
  bus_t    req_data;
  logic    rsp_valid;
  logic    rsp_ready;
  status_t rsp_status;
  err_t    rsp_err;
  addr_t   rsp_addr;
  bus_t    rsp_data;

  int vectors     = 0;
  int miscompares = 0;

  cell_mem_responder #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_err    (rsp_err),
    .rsp_addr   (rsp_addr),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, wait for its accept edge, then count edges until
  // rsp_valid is seen on a falling edge.
  task automatic send(input op_t op, input addr_t a, input bus_t d, output int lat);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int lat, input int exp_lat,
                            input status_t st, input err_t er, input addr_t ad,
                            input bus_t da);
    check({tag, "_lat"},    64'(lat), 64'(exp_lat));
    check({tag, "_valid"},  rsp_valid, 1);
    check({tag, "_status"}, rsp_status, st);
    check({tag, "_err"},    rsp_err, er);
    check({tag, "_addr"},   rsp_addr, ad);
    check({tag, "_data"},   rsp_data, da);
    take();
  endtask

  initial begin
    int lat;
    int exp_a;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_READ;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_valid",  rsp_valid, 0);
    check("rst_ready",  req_ready, 1);
    check("rst_status", rsp_status, status_ok);
    check("rst_err",    rsp_err, err_none);
    check("rst_addr",   rsp_addr, 0);
    check("rst_data",   rsp_data, 0);

    send(OP_ALLOC, 16'h0, 38'h1, lat);
    expect_rsp("alloc0", lat, 2, status_ok, err_none, 16'd0, 38'h0);
    send(OP_ALLOC, 16'h0, 38'h2, lat);
    expect_rsp("alloc1", lat, 2, status_ok, err_none, 16'd1, 38'h0);

    send(OP_STORE, 16'd5, 38'hABC, lat);
    expect_rsp("store5", lat, 1, status_ok, err_none, 16'd5, 38'h0);
    send(OP_READ, 16'd5, 38'h0, lat);
    expect_rsp("read5", lat, 1, status_ok, err_none, 16'd5, 38'hABC);
    send(OP_STORE, 16'd5, 38'h123, lat);
    expect_rsp("store5_used", lat, 1, status_err, err_mem_used, 16'd5, 38'h0);
    send(OP_READ, 16'd5, 38'h0, lat);
    expect_rsp("read5_kept", lat, 1, status_ok, err_none, 16'd5, 38'hABC);

    send(OP_READ, 16'h0100, 38'h0, lat);
    expect_rsp("read_oob", lat, 1, status_err, err_mem_full, 16'h0100, 38'h0);
    send(OP_READ, 16'd9, 38'h0, lat);
    expect_rsp("read9_unused", lat, 1, status_err, err_none, 16'd9, 38'h0);
    send(OP_READ, 16'd0, 38'h0, lat);
    expect_rsp("read0", lat, 1, status_ok, err_none, 16'd0, 38'h1);
    send(OP_FREE, 16'd9, 38'h0, lat);
    expect_rsp("free9_unused", lat, 1, status_err, err_none, 16'd9, 38'h0);

    send(OP_READ, 16'd1, 38'h0, lat);
    check("hold_lat", 64'(lat), 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  rsp_valid, 1);
      check("hold_status", rsp_status, status_ok);
      check("hold_addr",   rsp_addr, 1);
      check("hold_data",   rsp_data, 38'h2);
      check("hold_ready",  req_ready, 0);
      @(negedge clk);
    end
    take();

    exp_a = 2;
    for (int i = 0; i < 253; i++) begin
      if (exp_a == 5) exp_a++;
      send(OP_ALLOC, 16'h0, 38'(i + 100), lat);
      check("fill_status", rsp_status, status_ok);
      check("fill_addr",   rsp_addr, 64'(exp_a));
      take();
      exp_a++;
    end
    check("count_full", dut.u_bitmap.count, 256);

    send(OP_ALLOC, 16'h0, 38'h5555, lat);
    expect_rsp("alloc_full", lat, 1, status_err, err_mem_full, 16'd0, 38'h0);
    send(OP_FREE, 16'd7, 38'h0, lat);
    expect_rsp("free7", lat, 1, status_ok, err_none, 16'd7, 38'h0);
    send(OP_ALLOC, 16'h0, 38'h7777, lat);
    expect_rsp("alloc_wrap7", lat, 9, status_ok, err_none, 16'd7, 38'h0);
    send(OP_READ, 16'd7, 38'h0, lat);
    expect_rsp("read7", lat, 1, status_ok, err_none, 16'd7, 38'h7777);
    send(OP_READ, 16'd255, 38'h0, lat);
    expect_rsp("read255", lat, 1, status_ok, err_none, 16'd255, 38'(252 + 100));

    send(OP_FREE, 16'd200, 38'h0, lat);
    expect_rsp("free200", lat, 1, status_ok, err_none, 16'd200, 38'h0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_ALLOC;
    req_data  = 38'h9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scan_no_valid", rsp_valid, 0);
    rst = 1'b1;
    #1;
    check("midscan_rst_valid", rsp_valid, 0);
    check("midscan_rst_count", dut.u_bitmap.count, 0);
    check("midscan_rst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 0);

    send(OP_ALLOC, 16'h0, 38'h42, lat);
    expect_rsp("post_rst_alloc", lat, 2, status_ok, err_none, 16'd0, 38'h0);
    send(OP_READ, 16'd3, 38'h0, lat);
    expect_rsp("post_rst_read3", lat, 1, status_err, err_none, 16'd3, 38'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
